// File: rtl/roce_tx_pkg.sv
// Shared types and field layout for the RoCE TX request sequencer.
package roce_tx_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_SEND  = 3'd2
  } roce_op_e;

  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned QPN_LSB   = 3;
  localparam int unsigned QPN_W     = 24;
  localparam int unsigned LADDR_LSB = 27;
  localparam int unsigned RADDR_LSB = 75;
  localparam int unsigned ADDR_W    = 48;
  localparam int unsigned LEN_LSB   = 123;
  localparam int unsigned LEN_W     = 32;

  localparam int unsigned STATUS_CODE_LSB = 24;
  localparam int unsigned STATUS_CODE_W   = 8;

  localparam int unsigned WORDS_PER_BEAT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_META,
    S_DATA,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  // Byte enables for the final beat: a zero remainder means a full beat.
  function automatic logic [63:0] last_keep(input logic [5:0] rem);
    return (rem == 6'd0) ? '1 : ((64'd1 << rem) - 64'd1);
  endfunction

endpackage

// File: rtl/roce_tx_beat_gen.sv
// Payload beat generator for a single transfer: beat count, tkeep/tlast and counter pattern.
module roce_tx_beat_gen
  import roce_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         xfer_bytes,
  input  logic [31:0]         word_base,
  input  logic                tready,
  output logic                tvalid,
  output logic [DATA_W-1:0]   tdata,
  output logic [DATA_W/8-1:0] tkeep,
  output logic                tlast,
  output logic                beat_fire,
  output logic                done
);

  logic        active_q, active_d;
  logic [26:0] left_q, left_d;

  assign tvalid    = active_q;
  assign tlast     = active_q && (left_q == 27'd1);
  assign beat_fire = tvalid && tready;
  assign done      = beat_fire && tlast;
  assign tkeep     = tlast ? last_keep(xfer_bytes[5:0]) : '1;

  // word_base only advances on a beat handshake, so the payload is stable while stalled.
  always_comb begin
    tdata = '0;
    for (int unsigned i = 0; i < DATA_W / 32; i++) begin
      tdata[i*32 +: 32] = word_base + 32'(i);
    end
  end

  always_comb begin
    active_d = active_q;
    left_d   = left_q;
    if (start) begin
      active_d = 1'b1;
      left_d   = {1'b0, xfer_bytes[31:6]} + 27'(|xfer_bytes[5:0]);
    end else if (beat_fire) begin
      left_d = left_q - 27'd1;
      if (tlast) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      left_q   <= '0;
    end else begin
      active_q <= active_d;
      left_q   <= left_d;
    end
  end

endmodule

// File: rtl/roce_tx_sequencer.sv
// Issues a run of RDMA WRITE requests (meta + counter payload), bounds in-flight
// requests, drains completions and reports through the ap_ctrl handshake.
module roce_tx_sequencer
  import roce_tx_pkg::*;
#(
  parameter int unsigned META_W          = 256,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned STATUS_W        = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  ap_ready,
  input  logic [23:0]           cfg_qpn,
  input  logic [31:0]           cfg_num_xfers,
  input  logic [31:0]           cfg_xfer_bytes,
  input  logic [47:0]           cfg_local_vaddr,
  input  logic [47:0]           cfg_remote_vaddr,
  output logic                  m_axis_tx_meta_tvalid,
  input  logic                  m_axis_tx_meta_tready,
  output logic [META_W-1:0]     m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]   m_axis_tx_meta_tkeep,
  output logic                  m_axis_tx_meta_tlast,
  output logic                  m_axis_tx_data_tvalid,
  input  logic                  m_axis_tx_data_tready,
  output logic [DATA_W-1:0]     m_axis_tx_data_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tx_data_tkeep,
  output logic                  m_axis_tx_data_tlast,
  input  logic                  s_axis_tx_status_tvalid,
  output logic                  s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]   s_axis_tx_status_tdata,
  input  logic [STATUS_W/8-1:0] s_axis_tx_status_tkeep,
  input  logic                  s_axis_tx_status_tlast,
  output logic [31:0]           err_count,
  output logic [31:0]           status_count
);

  seq_state_e  state_q, state_d;
  logic        start_d_q;
  logic [23:0] qpn_q, qpn_d;
  logic [31:0] num_q, num_d, bytes_q, bytes_d, x_q, x_d;
  logic [47:0] laddr_q, laddr_d, raddr_q, raddr_d;
  logic [8:0]  outst_q, outst_d;
  logic [31:0] word_base_q, word_base_d;
  logic [31:0] err_q, err_d, stat_q, stat_d;

  logic start_pulse, meta_fire, status_fire, status_dec;
  logic beat_start, beat_fire, beat_done;
  logic unused_status;

  assign start_pulse = ap_start && !start_d_q;
  assign ap_idle     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign ap_done     = (state_q == S_DONE);
  assign ap_ready    = (state_q == S_DONE);
  assign err_count    = err_q;
  assign status_count = stat_q;

  assign m_axis_tx_meta_tvalid = (state_q == S_META) && (outst_q < 9'(MAX_OUTSTANDING));
  assign m_axis_tx_meta_tkeep  = '1;
  assign m_axis_tx_meta_tlast  = 1'b1;
  assign meta_fire   = m_axis_tx_meta_tvalid && m_axis_tx_meta_tready;
  assign beat_start  = meta_fire;

  assign s_axis_tx_status_tready = (state_q != S_IDLE);
  assign status_fire = s_axis_tx_status_tvalid && s_axis_tx_status_tready;
  assign status_dec  = status_fire && (outst_q != 9'd0);
  assign unused_status = ^{s_axis_tx_status_tkeep, s_axis_tx_status_tlast,
                           s_axis_tx_status_tdata[STATUS_W-1:32],
                           s_axis_tx_status_tdata[23:0]};

  always_comb begin
    m_axis_tx_meta_tdata = '0;
    m_axis_tx_meta_tdata[OP_LSB +: OP_W]      = OP_WRITE;
    m_axis_tx_meta_tdata[QPN_LSB +: QPN_W]    = qpn_q;
    m_axis_tx_meta_tdata[LADDR_LSB +: ADDR_W] = laddr_q;
    m_axis_tx_meta_tdata[RADDR_LSB +: ADDR_W] = raddr_q;
    m_axis_tx_meta_tdata[LEN_LSB +: LEN_W]    = bytes_q;
  end

  roce_tx_beat_gen #(.DATA_W(DATA_W)) u_beat_gen (
    .clk        (ap_clk),
    .rst        (areset),
    .start      (beat_start),
    .xfer_bytes (bytes_q),
    .word_base  (word_base_q),
    .tready     (m_axis_tx_data_tready),
    .tvalid     (m_axis_tx_data_tvalid),
    .tdata      (m_axis_tx_data_tdata),
    .tkeep      (m_axis_tx_data_tkeep),
    .tlast      (m_axis_tx_data_tlast),
    .beat_fire  (beat_fire),
    .done       (beat_done)
  );

  always_comb begin
    state_d     = state_q;
    qpn_d       = qpn_q;
    num_d       = num_q;
    bytes_d     = bytes_q;
    x_d         = x_q;
    laddr_d     = laddr_q;
    raddr_d     = raddr_q;
    word_base_d = word_base_q;
    err_d       = err_q;
    stat_d      = stat_q;

    unique case (state_q)
      S_IDLE: if (start_pulse) begin
        qpn_d       = cfg_qpn;
        num_d       = cfg_num_xfers;
        bytes_d     = cfg_xfer_bytes;
        laddr_d     = cfg_local_vaddr;
        raddr_d     = cfg_remote_vaddr;
        x_d         = '0;
        word_base_d = '0;
        err_d       = '0;
        stat_d      = '0;
        state_d = (cfg_num_xfers == '0 || cfg_xfer_bytes == '0) ? S_DONE : S_META;
      end
      S_META:  if (meta_fire) state_d = S_DATA;
      // Addresses advance by one transfer length so no multiplier is needed.
      S_DATA: if (beat_done) begin
        x_d     = x_q + 32'd1;
        laddr_d = laddr_q + {16'd0, bytes_q};
        raddr_d = raddr_q + {16'd0, bytes_q};
        state_d = (x_q + 32'd1 < num_q) ? S_META : S_DRAIN;
      end
      S_DRAIN: if (outst_q == 9'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (beat_fire) word_base_d = word_base_q + 32'(WORDS_PER_BEAT);

    if (status_fire) begin
      stat_d = stat_q + 32'd1;
      if (s_axis_tx_status_tdata[STATUS_CODE_LSB +: STATUS_CODE_W] != '0 && err_q != '1)
        err_d = err_q + 32'd1;
    end

    outst_d = outst_q;
    unique case ({meta_fire, status_dec})
      2'b10:   outst_d = outst_q + 9'd1;
      2'b01:   outst_d = outst_q - 9'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      start_d_q   <= 1'b0;
      qpn_q       <= '0;
      num_q       <= '0;
      bytes_q     <= '0;
      x_q         <= '0;
      laddr_q     <= '0;
      raddr_q     <= '0;
      outst_q     <= '0;
      word_base_q <= '0;
      err_q       <= '0;
      stat_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_d_q   <= ap_start;
      qpn_q       <= qpn_d;
      num_q       <= num_d;
      bytes_q     <= bytes_d;
      x_q         <= x_d;
      laddr_q     <= laddr_d;
      raddr_q     <= raddr_d;
      outst_q     <= outst_d;
      word_base_q <= word_base_d;
      err_q       <= err_d;
      stat_q      <= stat_d;
    end
  end

endmodule

// File: tb/tb_roce_tx_sequencer.sv
// Scoreboard bench for roce_tx_sequencer: expected meta/data beats come from a run-level model.
module tb_roce_tx_sequencer;

  localparam int MAXO = 8;

  logic         ap_clk = 1'b0;
  logic         areset;
  logic         ap_start;
  logic         ap_idle, ap_done, ap_ready;
  logic [23:0]  cfg_qpn;
  logic [31:0]  cfg_num_xfers, cfg_xfer_bytes;
  logic [47:0]  cfg_local_vaddr, cfg_remote_vaddr;
  logic         meta_tvalid, meta_tready, meta_tlast;
  logic [255:0] meta_tdata;
  logic [31:0]  meta_tkeep;
  logic         data_tvalid, data_tready, data_tlast;
  logic [511:0] data_tdata;
  logic [63:0]  data_tkeep;
  logic         st_tvalid, st_tready;
  logic [511:0] st_tdata;
  logic [31:0]  err_count, status_count;

  always #5 ap_clk = ~ap_clk;

  roce_tx_sequencer #(.MAX_OUTSTANDING(MAXO)) dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .cfg_qpn(cfg_qpn), .cfg_num_xfers(cfg_num_xfers), .cfg_xfer_bytes(cfg_xfer_bytes),
    .cfg_local_vaddr(cfg_local_vaddr), .cfg_remote_vaddr(cfg_remote_vaddr),
    .m_axis_tx_meta_tvalid(meta_tvalid), .m_axis_tx_meta_tready(meta_tready),
    .m_axis_tx_meta_tdata(meta_tdata), .m_axis_tx_meta_tkeep(meta_tkeep),
    .m_axis_tx_meta_tlast(meta_tlast),
    .m_axis_tx_data_tvalid(data_tvalid), .m_axis_tx_data_tready(data_tready),
    .m_axis_tx_data_tdata(data_tdata), .m_axis_tx_data_tkeep(data_tkeep),
    .m_axis_tx_data_tlast(data_tlast),
    .s_axis_tx_status_tvalid(st_tvalid), .s_axis_tx_status_tready(st_tready),
    .s_axis_tx_status_tdata(st_tdata), .s_axis_tx_status_tkeep('1),
    .s_axis_tx_status_tlast(1'b1),
    .err_count(err_count), .status_count(status_count)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic [255:0] exp_meta_q[$];
  beat_t        exp_data_q[$];
  int           pend_due[$];
  logic [7:0]   code_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int meta_hs = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  bit hold_status = 1'b0;
  bit rand_rdy = 1'b0;
  bit st_fire_s = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Run-level model: byte addresses from x*len, payload words numbered across the whole run.
  task automatic build_model(input int unsigned num, input int unsigned bytes,
                             input logic [47:0] lb, input logic [47:0] rb, input logic [23:0] qpn);
    logic [31:0] word;
    word = 0;
    for (int unsigned x = 0; x < num; x++) begin
      logic [255:0] m;
      logic [63:0]  off;
      int unsigned  nbeats;
      off = 64'(x) * 64'(bytes);
      m = '0;
      m[2:0]     = 3'd1;
      m[26:3]    = qpn;
      m[74:27]   = lb + off[47:0];
      m[122:75]  = rb + off[47:0];
      m[154:123] = bytes;
      exp_meta_q.push_back(m);
      nbeats = (bytes + 63) / 64;
      for (int unsigned b = 0; b < nbeats; b++) begin
        beat_t bt;
        int unsigned rem;
        for (int unsigned i = 0; i < 16; i++) bt.d[i*32 +: 32] = word + 32'(i);
        bt.l = (b == nbeats - 1);
        rem  = bytes % 64;
        bt.k = (bt.l && rem != 0) ? ((64'd1 << rem) - 64'd1) : {64{1'b1}};
        exp_data_q.push_back(bt);
        word = word + 32'd16;
      end
    end
  endtask

  always @(posedge ap_clk) begin
    cyc++;
    #1;
    meta_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    data_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Status responder: returns one completion 10 cycles after each payload tlast.
  always @(posedge ap_clk) begin
    #1;
    if (areset) begin
      pend_due.delete();
      st_tvalid = 1'b0;
    end else begin
      if (st_fire_s) st_tvalid = 1'b0;
      if (!st_tvalid && !hold_status && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_due.pop_front());
        st_tdata = '0;
        st_tdata[23:0] = 24'($urandom);
        st_tdata[31:24] = (code_q.size() > 0) ? code_q.pop_front() : 8'h00;
        st_tvalid = 1'b1;
      end
    end
  end

  logic         m_stall, d_stall;
  logic [289:0] m_snap;
  logic [511:0] d_snap;
  logic [65:0]  d_ctl_snap;

  always @(negedge ap_clk) begin
    st_fire_s = st_tvalid && st_tready;
    if (!areset) begin
      if (ap_done) done_cnt++;
      if (ap_ready) ready_cnt++;
      if (m_stall) check("meta_hold", 512'({meta_tvalid, meta_tdata, meta_tkeep, meta_tlast}), 512'(m_snap));
      if (d_stall) begin
        check("data_hold", data_tdata, d_snap);
        check("data_ctl_hold", 512'({data_tvalid, data_tkeep, data_tlast}), 512'(d_ctl_snap));
      end
      m_stall = meta_tvalid && !meta_tready;
      m_snap  = {meta_tvalid, meta_tdata, meta_tkeep, meta_tlast};
      d_stall = data_tvalid && !data_tready;
      d_snap  = data_tdata;
      d_ctl_snap = {data_tvalid, data_tkeep, data_tlast};
      if (meta_tvalid && meta_tready) begin
        meta_hs++;
        if (exp_meta_q.size() == 0) check("meta_unexpected", 512'(1), 512'(0));
        else begin
          check("meta_tdata", 512'(meta_tdata), 512'(exp_meta_q.pop_front()));
          check("meta_keep_last", 512'({meta_tkeep, meta_tlast}), 512'({32'hFFFF_FFFF, 1'b1}));
        end
      end
      if (data_tvalid && data_tready) begin
        if (exp_data_q.size() == 0) check("data_unexpected", 512'(1), 512'(0));
        else begin
          beat_t e;
          e = exp_data_q.pop_front();
          check("data_tdata", data_tdata, e.d);
          check("data_keep_last", 512'({data_tkeep, data_tlast}), 512'({e.k, e.l}));
        end
        if (data_tlast) pend_due.push_back(cyc + 10);
      end
    end else begin
      m_stall = 1'b0;
      d_stall = 1'b0;
    end
  end

  task automatic start_run(input int unsigned num, input int unsigned bytes,
                           input logic [47:0] lb, input logic [47:0] rb, input logic [23:0] qpn);
    build_model(num, bytes, lb, rb, qpn);
    done_cnt  = 0;
    ready_cnt = 0;
    meta_hs   = 0;
    @(posedge ap_clk); #2;
    cfg_num_xfers = num; cfg_xfer_bytes = bytes;
    cfg_local_vaddr = lb; cfg_remote_vaddr = rb; cfg_qpn = qpn;
    ap_start = 1'b1;
    @(posedge ap_clk); #2;
    ap_start = 1'b0;
    cfg_num_xfers = $urandom; cfg_xfer_bytes = $urandom;
    cfg_local_vaddr = {$urandom, $urandom}; cfg_remote_vaddr = {$urandom, $urandom};
    cfg_qpn = 24'($urandom);
  endtask

  task automatic wait_done(input string name, input int unsigned num, input int unsigned exp_err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 512'(seen), 512'(1));
    repeat (3) @(negedge ap_clk);
    check({name, "_done_pulses"}, 512'(done_cnt), 512'(1));
    check({name, "_ready_pulses"}, 512'(ready_cnt), 512'(1));
    check({name, "_idle"}, 512'(ap_idle), 512'(1));
    check({name, "_status_count"}, 512'(status_count), 512'(num));
    check({name, "_err_count"}, 512'(err_count), 512'(exp_err));
    check({name, "_leftover"}, 512'(exp_meta_q.size() + exp_data_q.size()), 512'(0));
  endtask

  initial begin
    areset = 1'b1; ap_start = 1'b0;
    cfg_qpn = '0; cfg_num_xfers = '0; cfg_xfer_bytes = '0;
    cfg_local_vaddr = '0; cfg_remote_vaddr = '0;
    meta_tready = 1'b1; data_tready = 1'b1;
    st_tvalid = 1'b0; st_tdata = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_ctrl", 512'({ap_idle, ap_done, ap_ready}), 512'(3'b100));
    check("rst_valids", 512'({meta_tvalid, data_tvalid, st_tready}), 512'(0));
    check("rst_counts", 512'({err_count, status_count}), 512'(0));
    @(posedge ap_clk); #2; areset = 1'b0;

    // Single transfer, two full beats.
    code_q.push_back(8'h00);
    start_run(1, 128, 48'h1000_0000_0040, 48'h2000_0000_0000, 24'h12345);
    wait_done("basic", 1, 0);

    // Partial final beat (36 bytes).
    repeat (2) code_q.push_back(8'h00);
    start_run(2, 100, 48'h0000_0000_1000, 48'hFFFF_FFFF_FFC0, 24'h00ABC);
    wait_done("partial", 2, 0);

    // Outstanding limit with completions withheld.
    hold_status = 1'b1;
    repeat (20) code_q.push_back(8'h00);
    start_run(20, 64, 48'h0000_1234_0000, 48'h0000_5678_0000, 24'h000042);
    repeat (200) @(negedge ap_clk);
    check("outst_meta_hs", 512'(meta_hs), 512'(MAXO));
    check("outst_meta_blocked", 512'(meta_tvalid), 512'(0));
    hold_status = 1'b0;
    wait_done("outst", 20, 0);

    // Randomised backpressure and lengths; errors on two of five completions.
    rand_rdy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int unsigned bytes;
      int unsigned nerr;
      bytes = $urandom_range(1, 300);
      nerr = 0;
      for (int k = 0; k < 5; k++) begin
        logic [7:0] c;
        c = (k == 1 || k == 3) ? 8'h05 : 8'h00;
        if (c != 0) nerr++;
        code_q.push_back(c);
      end
      start_run(5, bytes, {$urandom, $urandom}, {$urandom, $urandom}, 24'($urandom));
      wait_done("random", 5, nerr);
    end
    rand_rdy = 1'b0;

    // Empty runs complete immediately without stream traffic.
    for (int z = 0; z < 2; z++) begin
      int lat;
      int act;
      lat = -1; act = 0;
      @(posedge ap_clk); #2;
      cfg_num_xfers = (z == 0) ? 32'd0 : 32'd4;
      cfg_xfer_bytes = (z == 0) ? 32'd64 : 32'd0;
      ap_start = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge ap_clk);
        if (meta_tvalid || data_tvalid) act++;
        if (ap_done && lat < 0) lat = k;
      end
      ap_start = 1'b0;
      check("zero_done_latency", 512'(lat >= 0 && lat <= 3), 512'(1));
      check("zero_no_traffic", 512'(act), 512'(0));
    end

    // Reset in the middle of a payload, then a clean run.
    begin
      bit seen;
      seen = 1'b0;
      start_run(2, 640, 48'h0, 48'h0, 24'h1);
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge ap_clk);
        if (data_tvalid) seen = 1'b1;
      end
      check("mid_data_reached", 512'(seen), 512'(1));
      #2; areset = 1'b1;
      @(posedge ap_clk); #1;
      check("mid_rst_valids", 512'({meta_tvalid, data_tvalid}), 512'(0));
      check("mid_rst_idle", 512'(ap_idle), 512'(1));
      exp_meta_q.delete(); exp_data_q.delete(); code_q.delete();
      @(posedge ap_clk); #2; areset = 1'b0;
      code_q.push_back(8'h00);
      start_run(1, 64, 48'h0000_0000_8000, 48'h0000_0000_9000, 24'h7);
      wait_done("post_rst", 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
